// File: rtl/layer_sequencer.sv
// Per-layer configuration sequencer: walks a host-written table, issues start/done
// handshakes to the accelerator and chains OFM addresses. Optional macro: SEQ_PERF_CNT_EN.
module layer_sequencer #(
   parameter int MAX_LAYERS = 10,
   parameter int OFM_ADDR_W = 22,
   parameter int CFG_WIDTH  = 59
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_we,
   input  logic [3:0]            cfg_addr,
   input  logic [CFG_WIDTH-1:0]  cfg_data,
   input  logic [3:0]            num_layers,
   input  logic                  run,
   output logic                  busy,
   output logic                  all_done,
   output logic                  start,
   input  logic                  done,
   output logic [3:0]            count_layer,
   output logic [8:0]            ifm_size,
   output logic [10:0]           ifm_channel,
   output logic [1:0]            kernel_size,
   output logic [10:0]           num_filter,
   output logic                  maxpool_mode,
   output logic [1:0]            maxpool_stride,
   output logic                  upsample_mode,
   output logic [OFM_ADDR_W-1:0] start_write_addr,
   output logic [OFM_ADDR_W-1:0] start_read_addr,
   output logic [31:0]           layer_cycles
);

   typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, NEXT, FINISH} state_t;

   state_t               state_reg, state_next;
   logic [CFG_WIDTH-1:0] table_reg [MAX_LAYERS];
   logic [3:0]           n_reg;
   logic [3:0]           count_reg;
   logic                 done_q;
   logic                 done_edge;
   logic [3:0]           n_clamped;
   logic [3:0]           load_idx;
   logic [CFG_WIDTH-1:0] load_word;

   assign done_edge   = done & ~done_q;
   assign n_clamped   = (num_layers > 4'(MAX_LAYERS)) ? 4'(MAX_LAYERS) : num_layers;
   assign count_layer = count_reg;

   // Config is registered on the edge entering LOAD so it is stable a full cycle before start.
   assign load_idx  = (state_reg == IDLE) ? 4'd0 : count_reg;
   assign load_word = (load_idx < 4'(MAX_LAYERS)) ? table_reg[load_idx] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      start      = 1'b0;
      all_done   = 1'b0;
      busy       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (run) begin
               state_next = (n_clamped == 4'd0) ? FINISH : LOAD;
            end
         end
         LOAD: begin
            busy       = 1'b1;
            state_next = START;
         end
         START: begin
            busy       = 1'b1;
            start      = 1'b1;
            state_next = WAIT;
         end
         WAIT: begin
            busy = 1'b1;
            if (done_edge) begin
               state_next = NEXT;
            end
         end
         NEXT: begin
            busy       = 1'b1;
            state_next = (count_reg == n_reg) ? FINISH : LOAD;
         end
         FINISH: begin
            all_done   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_LAYERS; i++) begin
            table_reg[i] <= '0;
         end
         n_reg            <= '0;
         count_reg        <= '0;
         done_q           <= 1'b0;
         ifm_size         <= '0;
         ifm_channel      <= '0;
         kernel_size      <= '0;
         num_filter       <= '0;
         maxpool_mode     <= 1'b0;
         maxpool_stride   <= '0;
         upsample_mode    <= 1'b0;
         start_write_addr <= '0;
         start_read_addr  <= '0;
      end else begin
         done_q <= done;
         if (state_reg == IDLE && cfg_we && cfg_addr < 4'(MAX_LAYERS)) begin
            table_reg[cfg_addr] <= cfg_data;
         end
         if (state_reg == IDLE && run) begin
            n_reg     <= n_clamped;
            count_reg <= 4'd1;
         end
         if (state_reg == NEXT && state_next == LOAD) begin
            count_reg <= count_reg + 4'd1;
         end
         if (state_next == LOAD) begin
            ifm_size         <= load_word[8:0];
            ifm_channel      <= load_word[19:9];
            kernel_size      <= load_word[21:20];
            num_filter       <= load_word[32:22];
            maxpool_mode     <= load_word[33];
            maxpool_stride   <= load_word[35:34];
            upsample_mode    <= load_word[36];
            start_write_addr <= load_word[37 +: OFM_ADDR_W];
            // Each layer reads the region the previous layer wrote.
            start_read_addr  <= (state_reg == IDLE) ? '0 : start_write_addr;
         end
      end
   end

`ifdef SEQ_PERF_CNT_EN
   logic [31:0] cyc_cnt_reg;
   logic [31:0] layer_cycles_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_cnt_reg      <= '0;
         layer_cycles_reg <= '0;
      end else if (state_reg == START) begin
         cyc_cnt_reg <= '0;
      end else if (state_reg == WAIT) begin
         if (done_edge) begin
            layer_cycles_reg <= cyc_cnt_reg;
         end
         if (cyc_cnt_reg != '1) begin
            cyc_cnt_reg <= cyc_cnt_reg + 32'd1;
         end
      end
   end

   assign layer_cycles = layer_cycles_reg;
`else
   assign layer_cycles = '0;
`endif

endmodule
